cacheline_burst_adaptor: RTL and testbench

Bridges the cache's 256-bit line interface to the 64-bit burst interface of physical memory. It sits directly downstream of the cache datapath. Line fills arrive as four 64-bit beats and are assembled into `line_o`. Dirty-line write-backs are split from `line_i` into four 64-bit beats. The cache controller sees a single request/response handshake per line.

---
 rtl/cacheline_burst_adaptor.sv | 148 ++++++++++++++
 tb/tb_cacheline_burst_adaptor.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cacheline_burst_adaptor.sv
// Bridges a 256-bit cache line port to a 64-bit memory burst port (fill assembly, write-back split).
// Optional watchdog on stalled beats: define CACHELINE_ADAPTOR_ERR_EN.
`timescale 1ns/1ps
module cacheline_burst_adaptor #(
  parameter int unsigned s_line    = 256,
  parameter int unsigned s_burst   = 64,
  parameter int unsigned num_beats = s_line / s_burst,
  parameter int unsigned timeout   = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                read_i,
  input  logic                write_i,
  input  logic [31:0]         address_i,
  input  logic [s_line-1:0]   line_i,
  output logic [s_line-1:0]   line_o,
  output logic                resp_o,
  output logic                err_o,
  input  logic [s_burst-1:0]  burst_i,
  output logic [s_burst-1:0]  burst_o,
  output logic [31:0]         address_o,
  output logic                read_o,
  output logic                write_o,
  input  logic                resp_i
);

  localparam int unsigned cnt_w = $clog2(num_beats);
  localparam int unsigned off_w = $clog2(s_line / 8);
  localparam logic [cnt_w-1:0] last_beat = cnt_w'(num_beats - 1);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_e;

  state_e             state_q, state_d;
  logic [cnt_w-1:0]   cnt_q, cnt_d;
  logic [s_line-1:0]  line_buf_q, line_buf_d;
  logic [31:0]        addr_d;
  logic [s_burst-1:0] burst_d;
  logic               read_d, write_d, resp_d;
  int unsigned        beat_idx, next_idx;
  logic               unused_bits;

`ifdef CACHELINE_ADAPTOR_ERR_EN
  localparam int unsigned wd_w = $clog2(timeout + 1);
  logic [wd_w-1:0] wdog_q, wdog_d;
  logic            err_d;
`endif

  assign line_o = line_buf_q;

  // Next-state, datapath and registered-output decode
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    line_buf_d = line_buf_q;
    addr_d     = address_o;
    beat_idx   = 32'(cnt_q) * s_burst;
`ifdef CACHELINE_ADAPTOR_ERR_EN
    wdog_d     = wdog_q;
    err_d      = 1'b0;
`endif
    case (state_q)
      IDLE: begin
`ifdef CACHELINE_ADAPTOR_ERR_EN
        wdog_d = '0;
`endif
        // Write-back wins so a dirty victim leaves before its refill lands
        if (write_i) begin
          line_buf_d = line_i;
          cnt_d      = '0;
          addr_d     = {address_i[31:off_w], off_w'(0)};
          state_d    = WRITE;
        end else if (read_i) begin
          cnt_d   = '0;
          addr_d  = {address_i[31:off_w], off_w'(0)};
          state_d = READ;
        end
      end
      READ, WRITE: begin
        if (resp_i) begin
          if (state_q == READ) line_buf_d[beat_idx +: s_burst] = burst_i;
          cnt_d = cnt_q + cnt_w'(1);
          if (cnt_q == last_beat) state_d = DONE;
`ifdef CACHELINE_ADAPTOR_ERR_EN
          wdog_d = '0;
`endif
        end
`ifdef CACHELINE_ADAPTOR_ERR_EN
        else if (wdog_q == wd_w'(timeout - 1)) begin
          wdog_d  = '0;
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          wdog_d = wdog_q + wd_w'(1);
        end
`endif
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    next_idx = 32'(cnt_d) * s_burst;
    read_d   = (state_d == READ);
    write_d  = (state_d == WRITE);
    resp_d   = (state_d == DONE);
    burst_d  = write_d ? line_buf_d[next_idx +: s_burst] : '0;
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      line_buf_q <= '0;
      address_o  <= '0;
      burst_o    <= '0;
      read_o     <= 1'b0;
      write_o    <= 1'b0;
      resp_o     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      line_buf_q <= line_buf_d;
      address_o  <= addr_d;
      burst_o    <= burst_d;
      read_o     <= read_d;
      write_o    <= write_d;
      resp_o     <= resp_d;
    end
  end

`ifdef CACHELINE_ADAPTOR_ERR_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wdog_q <= '0;
      err_o  <= 1'b0;
    end else begin
      wdog_q <= wdog_d;
      err_o  <= err_d;
    end
  end

  assign unused_bits = ^address_i[off_w-1:0];
`else
  assign err_o       = 1'b0;
  assign unused_bits = ^{address_i[off_w-1:0], (timeout == 0)};
`endif

endmodule

// File: tb/tb_cacheline_burst_adaptor.sv
// Directed self-checking bench for cacheline_burst_adaptor (fill, write-back, priority, reset, DONE).
`timescale 1ns/1ps
module tb_cacheline_burst_adaptor;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         read_i = 1'b0, write_i = 1'b0, resp_i = 1'b0;
  logic [31:0]  address_i = '0;
  logic [255:0] line_i = '0;
  logic [255:0] line_o;
  logic         resp_o, err_o, read_o, write_o;
  logic [63:0]  burst_i = '0;
  logic [63:0]  burst_o;
  logic [31:0]  address_o;

  int checks = 0;
  int failures = 0;

  cacheline_burst_adaptor #(.s_line(256), .s_burst(64), .num_beats(4), .timeout(8)) dut (
    .clk(clk), .rst(rst), .read_i(read_i), .write_i(write_i), .address_i(address_i),
    .line_i(line_i), .line_o(line_o), .resp_o(resp_o), .err_o(err_o), .burst_i(burst_i),
    .burst_o(burst_o), .address_o(address_o), .read_o(read_o), .write_o(write_o), .resp_i(resp_i)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] rep(input logic [7:0] x);
    return {8{x}};
  endfunction

  logic [63:0]  d0, d1, d2, d3;
  logic [63:0]  wexp [6];
  logic [63:0]  nb [4];
  logic [5:0]   rp_w;
  logic [4:0]   rp_f;
  logic [255:0] fill_line, last_line;
  int           k;

  initial begin
    // Reset values
    repeat (2) step();
    chk("rst_line_o", line_o, '0);
    chk("rst_resp_o", resp_o, 0);
    chk("rst_err_o", err_o, 0);
    chk("rst_burst_o", burst_o, '0);
    chk("rst_address_o", address_o, '0);
    chk("rst_read_o", read_o, 0);
    chk("rst_write_o", write_o, 0);
    rst = 1'b1;
    step();

    // Fill at 0x1234, no stalls
    address_i = 32'h0000_1234;
    read_i = 1'b1;
    step();
    chk("fill_address_o", address_o, 32'h0000_1220);
    chk("fill_read_o", read_o, 1);
    chk("fill_write_o", write_o, 0);
    for (int i = 0; i < 4; i++) begin
      resp_i = 1'b1;
      burst_i = rep(8'(8'h11 * (i + 1)));
      step();
      if (i < 3) chk("fill_resp_early", resp_o, 0);
    end
    fill_line = {rep(8'h44), rep(8'h33), rep(8'h22), rep(8'h11)};
    chk("fill_resp_c5", resp_o, 1);
    chk("fill_err_c5", err_o, 0);
    chk("fill_line_o", line_o, fill_line);
    chk("fill_read_done", read_o, 0);

    // Requests and resp_i during DONE are ignored
    read_i = 1'b0;
    write_i = 1'b1;
    resp_i = 1'b1;
    address_i = 32'hFFFF_FFFF;
    burst_i = '1;
    step();
    write_i = 1'b0;
    resp_i = 1'b0;
    burst_i = '0;
    chk("done_resp_cleared", resp_o, 0);
    chk("done_no_write", write_o, 0);
    chk("done_no_read", read_o, 0);
    chk("done_addr_kept", address_o, 32'h0000_1220);
    chk("done_line_kept", line_o, fill_line);
    step();
    chk("idle_no_write", write_o, 0);
    chk("idle_line_kept", line_o, fill_line);

    // Write-back with stalls: burst_o D0,D0,D1,D1,D2,D3
    d0 = 64'h0123_4567_89AB_CDEF;
    d1 = 64'hFEDC_BA98_7654_3210;
    d2 = 64'hDEAD_BEEF_0000_0001;
    d3 = 64'hCAFE_F00D_5555_AAAA;
    wexp[0] = d0; wexp[1] = d0; wexp[2] = d1;
    wexp[3] = d1; wexp[4] = d2; wexp[5] = d3;
    rp_w = 6'b111010;
    line_i = {d3, d2, d1, d0};
    address_i = 32'hABCD_EF7F;
    write_i = 1'b1;
    step();
    line_i = '0;
    address_i = '0;
    chk("wb_address_o", address_o, 32'hABCD_EF60);
    for (int c = 0; c < 6; c++) begin
      chk("wb_burst_o", burst_o, wexp[c]);
      chk("wb_write_o", write_o, 1);
      chk("wb_read_o", read_o, 0);
      chk("wb_resp_early", resp_o, 0);
      resp_i = rp_w[c];
      step();
    end
    chk("wb_resp_c7", resp_o, 1);
    chk("wb_burst_zero", burst_o, '0);
    chk("wb_write_done", write_o, 0);
    chk("wb_read_done", read_o, 0);
    write_i = 1'b0;
    resp_i = 1'b0;
    step();

    // Both requests: write first, held read starts after DONE
    line_i = {rep(8'hD3), rep(8'hD2), rep(8'hD1), rep(8'hD0)};
    address_i = 32'h0000_0040;
    read_i = 1'b1;
    write_i = 1'b1;
    step();
    chk("both_write_o", write_o, 1);
    chk("both_read_o", read_o, 0);
    chk("both_burst_d0", burst_o, rep(8'hD0));
    for (int i = 0; i < 4; i++) begin
      resp_i = 1'b1;
      step();
    end
    chk("both_wb_resp", resp_o, 1);
    write_i = 1'b0;
    resp_i = 1'b0;
    step();
    chk("both_idle_read", read_o, 0);
    step();
    chk("both_read_started", read_o, 1);
    chk("both_read_nowrite", write_o, 0);
    for (int i = 0; i < 4; i++) begin
      resp_i = 1'b1;
      burst_i = rep(8'(8'hA1 + i));
      step();
    end
    chk("both_fill_resp", resp_o, 1);
    chk("both_fill_line", line_o, {rep(8'hA4), rep(8'hA3), rep(8'hA2), rep(8'hA1)});
    read_i = 1'b0;
    resp_i = 1'b0;
    step();

    // Reset after two beats of a fill
    address_i = 32'h0000_2000;
    read_i = 1'b1;
    step();
    resp_i = 1'b1;
    burst_i = rep(8'h55);
    step();
    burst_i = rep(8'h66);
    step();
    rst = 1'b0;
    read_i = 1'b0;
    resp_i = 1'b0;
    #1;
    chk("mrst_line_o", line_o, '0);
    chk("mrst_read_o", read_o, 0);
    chk("mrst_address_o", address_o, '0);
    chk("mrst_resp_o", resp_o, 0);
    chk("mrst_burst_o", burst_o, '0);
    chk("mrst_write_o", write_o, 0);
    chk("mrst_err_o", err_o, 0);
    step();
    rst = 1'b1;
    step();

    // Fresh fill after reset, one stall in the second cycle
    nb[0] = rep(8'h77); nb[1] = rep(8'h88); nb[2] = rep(8'h99); nb[3] = rep(8'hAA);
    rp_f = 5'b11101;
    k = 0;
    address_i = 32'h0000_3000;
    read_i = 1'b1;
    step();
    chk("refill_address_o", address_o, 32'h0000_3000);
    for (int c = 0; c < 5; c++) begin
      if (rp_f[c]) begin
        resp_i = 1'b1;
        burst_i = nb[k];
        k++;
      end else begin
        resp_i = 1'b0;
        burst_i = rep(8'hEE);
      end
      step();
      if (c < 4) chk("refill_resp_early", resp_o, 0);
    end
    last_line = {nb[3], nb[2], nb[1], nb[0]};
    chk("refill_resp_c6", resp_o, 1);
    chk("refill_line_o", line_o, last_line);
    read_i = 1'b0;
    resp_i = 1'b0;
    step();

`ifdef CACHELINE_ADAPTOR_ERR_EN
    // Watchdog: READ with resp_i stuck low
    address_i = 32'h0000_4000;
    read_i = 1'b1;
    step();
    for (int i = 1; i <= 8; i++) begin
      step();
      if (i < 8) chk("wd_resp_early", resp_o, 0);
    end
    chk("wd_resp_o", resp_o, 1);
    chk("wd_err_o", err_o, 1);
    chk("wd_line_partial", line_o, last_line);
    read_i = 1'b0;
    step();
    chk("wd_resp_cleared", resp_o, 0);
    chk("wd_err_cleared", err_o, 0);
    chk("wd_read_idle", read_o, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
